// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared constants, state encoding and helpers for the command loopback monitor
package cmd_pkg;

  localparam int          FRAME_W       = 16;
  localparam logic [15:0] SYNC_WORD_DEF = 16'h817E;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } rx_state_e;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cmd_rx_align.sv
// rtl/cmd_rx_align.sv - serial sampler, word aligner and sync lock state machine
module cmd_rx_align
  import cmd_pkg::*;
#(
  parameter logic [FRAME_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int                 LOCK_CNT  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ser_in,
  input  logic               i_ser_en,
  input  logic               i_clear,
  output logic [FRAME_W-1:0] o_word,
  output logic               o_word_stb,
  output logic               o_is_sync,
  output logic               o_locked
);

  localparam logic [3:0] LP_LOCK = LOCK_CNT[3:0];

  rx_state_e          r_state;
  rx_state_e          w_state_next;
  logic [FRAME_W-1:0] r_sr;
  logic [3:0]         r_bit_cnt;
  logic [3:0]         r_lock_cnt;
  logic               r_en_d;

  logic [FRAME_W-1:0] w_sr_next;
  logic               w_match;
  logic               w_en_fall;
  logic               w_word_done;

  assign w_sr_next   = {r_sr[FRAME_W-2:0], i_ser_in};
  assign w_match     = (w_sr_next == SYNC_WORD);
  assign w_en_fall   = r_en_d & ~i_ser_en;
  // A word completes on the 16th sampled bit after the boundary (counter wraps 15->0).
  assign w_word_done = i_ser_en & (r_bit_cnt == 4'd15);

  // State register; CLEAR behaves like a synchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_UNLOCKED;
    end else if (i_clear) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: bit-level search when unlocked, word-level checks once aligned.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_UNLOCKED: begin
        if (i_ser_en && w_match) begin
          w_state_next = (LOCK_CNT == 1) ? ST_LOCKED : ST_LOCKING;
        end
      end
      ST_LOCKING: begin
        if (w_en_fall) begin
          w_state_next = ST_UNLOCKED;
        end else if (w_word_done) begin
          if (!w_match) begin
            w_state_next = ST_UNLOCKED;
          end else if (r_lock_cnt + 4'd1 == LP_LOCK) begin
            w_state_next = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (w_en_fall) begin
          w_state_next = ST_UNLOCKED;
        end
      end
      default: w_state_next = ST_UNLOCKED;
    endcase
  end

  // Shift register, bit counter and lock counter; everything holds while SER_EN is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_lock_cnt <= '0;
      r_en_d     <= 1'b0;
    end else if (i_clear) begin
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_lock_cnt <= '0;
      r_en_d     <= 1'b0;
    end else begin
      r_en_d <= i_ser_en;
      if (i_ser_en) begin
        r_sr <= w_sr_next;
      end
      case (r_state)
        ST_UNLOCKED: begin
          if (i_ser_en && w_match) begin
            r_bit_cnt  <= '0;
            r_lock_cnt <= 4'd1;
          end
        end
        ST_LOCKING: begin
          if (w_en_fall) begin
            r_bit_cnt  <= '0;
            r_lock_cnt <= '0;
          end else if (i_ser_en) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_word_done) begin
              r_lock_cnt <= w_match ? r_lock_cnt + 4'd1 : 4'd0;
            end
          end
        end
        ST_LOCKED: begin
          if (w_en_fall) begin
            r_bit_cnt <= '0;
          end else if (i_ser_en) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        default: begin
          r_bit_cnt  <= '0;
          r_lock_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs: the completed word is presented combinationally on its last bit so the
  // buffer can capture it at the same edge.
  always_comb begin
    o_word     = w_sr_next;
    o_word_stb = (r_state == ST_LOCKED) & w_word_done;
    o_is_sync  = w_match;
    o_locked   = (r_state == ST_LOCKED);
  end

endmodule

// File: rtl/cmd_rx_monitor.sv
// rtl/cmd_rx_monitor.sv - command loopback monitor: aligner, one-entry frame buffer and statistics
module cmd_rx_monitor
  import cmd_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int          LOCK_CNT  = 4,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 CMD_CLK,
  input  logic                 CMD_RST_N,
  input  logic                 SER_IN,
  input  logic                 SER_EN,
  input  logic                 CLEAR,
  output logic [FRAME_W-1:0]   FRAME_DATA,
  output logic                 FRAME_VALID,
  input  logic                 FRAME_READY,
  output logic                 LOCKED,
  output logic [CNT_WIDTH-1:0] FRAME_CNT,
  output logic [CNT_WIDTH-1:0] SYNC_CNT,
  output logic [7:0]           OVF_CNT,
  output logic                 OVERFLOW
);

  localparam logic [31:0] LP_CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

  logic [FRAME_W-1:0]   w_word;
  logic                 w_word_stb;
  logic                 w_is_sync;
  logic                 w_locked;
  logic                 w_frame;
  logic                 w_sync;

  logic [FRAME_W-1:0]   r_data;
  logic                 r_valid;
  logic [CNT_WIDTH-1:0] r_frame_cnt;
  logic [CNT_WIDTH-1:0] r_sync_cnt;
  logic [7:0]           r_ovf_cnt;
  logic                 r_overflow;

  cmd_rx_align #(
    .SYNC_WORD (SYNC_WORD),
    .LOCK_CNT  (LOCK_CNT)
  ) u_align (
    .i_clk      (CMD_CLK),
    .i_rst_n    (CMD_RST_N),
    .i_ser_in   (SER_IN),
    .i_ser_en   (SER_EN),
    .i_clear    (CLEAR),
    .o_word     (w_word),
    .o_word_stb (w_word_stb),
    .o_is_sync  (w_is_sync),
    .o_locked   (w_locked)
  );

  assign w_frame = w_word_stb & ~w_is_sync;
  assign w_sync  = w_word_stb & w_is_sync;

  // Frame buffer: load when empty or being consumed this edge, otherwise drop and count.
  always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
    if (!CMD_RST_N) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_cnt <= '0;
      r_ovf_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else if (CLEAR) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_cnt <= '0;
      r_ovf_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else if (w_frame) begin
      if (!r_valid || FRAME_READY) begin
        r_data      <= w_word;
        r_valid     <= 1'b1;
        r_frame_cnt <= CNT_WIDTH'(sat_inc(32'(r_frame_cnt), LP_CNT_MAX));
      end else begin
        r_ovf_cnt  <= 8'(sat_inc(32'(r_ovf_cnt), 32'd255));
        r_overflow <= 1'b1;
      end
    end else if (r_valid && FRAME_READY) begin
      r_valid <= 1'b0;
    end
  end

  // Sync words seen in lock are stripped and only counted.
  always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
    if (!CMD_RST_N) begin
      r_sync_cnt <= '0;
    end else if (CLEAR) begin
      r_sync_cnt <= '0;
    end else if (w_sync) begin
      r_sync_cnt <= CNT_WIDTH'(sat_inc(32'(r_sync_cnt), LP_CNT_MAX));
    end
  end

  assign FRAME_DATA  = r_data;
  assign FRAME_VALID = r_valid;
  assign LOCKED      = w_locked;
  assign FRAME_CNT   = r_frame_cnt;
  assign SYNC_CNT    = r_sync_cnt;
  assign OVF_CNT     = r_ovf_cnt;
  assign OVERFLOW    = r_overflow;

endmodule

// File: tb/tb_cmd_rx_monitor.sv
// tb/tb_cmd_rx_monitor.sv - self-checking bench for cmd_rx_monitor against a word-level reference model
module tb_cmd_rx_monitor;

  localparam logic [15:0] SYNC  = 16'h817E;
  localparam int          LOCKN = 4;

  logic        clk = 1'b0;
  logic        rst_n, ser_in, ser_en, clear, ready;
  logic [15:0] frame_data;
  logic        frame_valid, locked, overflow;
  logic [15:0] frame_cnt, sync_cnt;
  logic [7:0]  ovf_cnt;

  always #5 clk = ~clk;

  cmd_rx_monitor #(.SYNC_WORD(SYNC), .LOCK_CNT(LOCKN), .CNT_WIDTH(16)) dut (
    .CMD_CLK     (clk),
    .CMD_RST_N   (rst_n),
    .SER_IN      (ser_in),
    .SER_EN      (ser_en),
    .CLEAR       (clear),
    .FRAME_DATA  (frame_data),
    .FRAME_VALID (frame_valid),
    .FRAME_READY (ready),
    .LOCKED      (locked),
    .FRAME_CNT   (frame_cnt),
    .SYNC_CNT    (sync_cnt),
    .OVF_CNT     (ovf_cnt),
    .OVERFLOW    (overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 searching, 1 collecting lock words, 2 locked.
  int m_mode, m_sr, m_since, m_locks, m_prev_en;
  int m_valid, m_data, m_fcnt, m_scnt, m_ocnt, m_ovf;

  task automatic m_reset();
    m_mode = 0; m_sr = 0; m_since = 0; m_locks = 0; m_prev_en = 0;
    m_valid = 0; m_data = 0; m_fcnt = 0; m_scnt = 0; m_ocnt = 0; m_ovf = 0;
  endtask

  task automatic m_step(input bit b, input bit en, input bit rdy, input bit clr);
    bit done, frame;
    done = 0;
    frame = 0;
    if (clr) begin
      m_reset();
      return;
    end
    if (m_prev_en && !en && m_mode != 0) begin
      m_mode = 0; m_since = 0; m_locks = 0;
    end else if (en) begin
      m_sr = ((m_sr << 1) | int'(b)) & 32'hFFFF;
      if (m_mode == 0) begin
        if (m_sr == int'(SYNC)) begin
          m_since = 0; m_locks = 1; m_mode = (LOCKN == 1) ? 2 : 1;
        end
      end else begin
        m_since++;
        if (m_since == 16) begin
          m_since = 0; done = 1;
        end
      end
    end
    if (done) begin
      if (m_mode == 1) begin
        if (m_sr == int'(SYNC)) begin
          m_locks++;
          if (m_locks == LOCKN) m_mode = 2;
        end else begin
          m_mode = 0; m_locks = 0;
        end
      end else begin
        if (m_sr == int'(SYNC)) m_scnt = (m_scnt < 65535) ? m_scnt + 1 : m_scnt;
        else frame = 1;
      end
    end
    if (frame) begin
      if (m_valid == 0 || rdy) begin
        m_valid = 1; m_data = m_sr;
        m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : m_fcnt;
      end else begin
        m_ocnt = (m_ocnt < 255) ? m_ocnt + 1 : m_ocnt;
        m_ovf = 1;
      end
    end else if (m_valid == 1 && rdy) begin
      m_valid = 0;
    end
    m_prev_en = int'(en);
  endtask

  task automatic check_all();
    chk("locked",      32'(locked),      32'(m_mode == 2));
    chk("frame_valid", 32'(frame_valid), m_valid);
    chk("frame_data",  32'(frame_data),  m_data);
    chk("frame_cnt",   32'(frame_cnt),   m_fcnt);
    chk("sync_cnt",    32'(sync_cnt),    m_scnt);
    chk("ovf_cnt",     32'(ovf_cnt),     m_ocnt);
    chk("overflow",    32'(overflow),    m_ovf);
  endtask

  task automatic cyc(input bit b, input bit en, input bit rdy, input bit clr);
    ser_in = b; ser_en = en; ready = rdy; clear = clr;
    @(posedge clk);
    m_step(b, en, rdy, clr);
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [15:0] w, input bit rdy, input bit rdy_last);
    for (int i = 15; i >= 1; i--) cyc(w[i], 1'b1, rdy, 1'b0);
    cyc(w[0], 1'b1, rdy_last, 1'b0);
  endtask

  task automatic send_syncs(input int n);
    for (int k = 0; k < n; k++) send_word(SYNC, 1'b1, 1'b1);
  endtask

  initial begin
    logic [15:0] w;
    int r, n;
    rst_n = 1'b0; ser_in = 1'b0; ser_en = 1'b0; clear = 1'b0; ready = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;

    // Lock at odd offset
    repeat (5) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    send_syncs(3);
    chk("lock_not_yet", 32'(locked), 32'd0);
    send_syncs(1);
    chk("lock_after_4", 32'(locked), 32'd1);
    chk("lock_scnt", 32'(sync_cnt), 32'd0);
    chk("lock_valid", 32'(frame_valid), 32'd0);

    // Frame delivery then a stripped sync
    send_word(16'hA5C3, 1'b1, 1'b1);
    chk("dlv_valid", 32'(frame_valid), 32'd1);
    chk("dlv_data", 32'(frame_data), 32'hA5C3);
    chk("dlv_fcnt", 32'(frame_cnt), 32'd1);
    send_syncs(1);
    chk("dlv_scnt", 32'(sync_cnt), 32'd1);
    chk("dlv_novalid", 32'(frame_valid), 32'd0);

    // Lock failure after CLEAR
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_locked", 32'(locked), 32'd0);
    chk("clr_fcnt", 32'(frame_cnt), 32'd0);
    send_syncs(2);
    send_word(16'h1234, 1'b1, 1'b1);
    chk("fail_locked", 32'(locked), 32'd0);
    chk("fail_valid", 32'(frame_valid), 32'd0);
    send_syncs(4);
    chk("relock", 32'(locked), 32'd1);

    // Backpressure
    send_word(16'h0001, 1'b0, 1'b0);
    send_word(16'h0002, 1'b0, 1'b0);
    send_word(16'h0003, 1'b0, 1'b0);
    chk("bp_data", 32'(frame_data), 32'h0001);
    chk("bp_ovf_cnt", 32'(ovf_cnt), 32'd2);
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_fcnt", 32'(frame_cnt), 32'd1);

    // Handshake coinciding with a new frame
    send_word(16'hCAFE, 1'b1, 1'b0);
    chk("sim_cafe", 32'(frame_data), 32'hCAFE);
    send_word(16'hBEEF, 1'b0, 1'b1);
    chk("sim_data", 32'(frame_data), 32'hBEEF);
    chk("sim_valid", 32'(frame_valid), 32'd1);
    chk("sim_ovf", 32'(ovf_cnt), 32'd2);
    chk("sim_fcnt", 32'(frame_cnt), 32'd3);

    // SER_EN loss mid-frame, then asynchronous reset between edges
    w = 16'h5555;
    for (int i = 15; i >= 9; i--) cyc(w[i], 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("en_unlock", 32'(locked), 32'd0);
    chk("en_keep_valid", 32'(frame_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_valid", 32'(frame_valid), 32'd0);
    chk("arst_data", 32'(frame_data), 32'd0);
    chk("arst_fcnt", 32'(frame_cnt), 32'd0);
    chk("arst_ovf", 32'(ovf_cnt), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    #3;
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    send_syncs(4);
    chk("arst_relock", 32'(locked), 32'd1);

    // Overflow counter saturation
    for (int k = 0; k < 262; k++) send_word(16'h0F00 + 16'(k), 1'b0, 1'b0);
    chk("ovf_sat", 32'(ovf_cnt), 32'd255);
    chk("sat_locked", 32'(locked), 32'd1);

    // Randomized traffic
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 19);
      if (r < 7) begin
        send_word(SYNC, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r < 14) begin
        send_word(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r < 16) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) cyc(1'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end else if (r < 19) begin
        n = $urandom_range(1, 20);
        for (int k = 0; k < n; k++)
          cyc(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        cyc(1'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cmd_rx_monitor.md
Name: cmd_rx_monitor

Overview:
- Loopback monitor directly downstream of the command serializer.
- Samples the serial command stream (CMD_SERIAL_OUT qualified by CMD_OUTPUT_EN) one bit per CMD_CLK and word-aligns on the 16-bit sync symbol.
- Delivers every non-sync 16-bit frame on a valid/ready port so firmware/DAQ can check what the chip actually received.
- Lives in the CMD_CLK domain; statistics are exported as plain counters for the register block to sample.

Parameters:
- SYNC_WORD, 16'h817E, sync symbol searched for and stripped; compared MSB-first.
- LOCK_CNT, 4, consecutive aligned sync words needed to declare lock (legal range 1..15).
- CNT_WIDTH, 16, width of the frame and sync statistics counters.

Ports:
- CMD_CLK  input  1  command clock; sole clock.
- CMD_RST_N  input  1  asynchronous, active-low reset.
- SER_IN  input  1  serial command bit (CMD_SERIAL_OUT), MSB of each 16-bit word first.
- SER_EN  input  1  SER_IN qualifier (CMD_OUTPUT_EN); a bit is sampled only when high.
- CLEAR  input  1  synchronous pulse: zero all counters and the overflow flag, return to UNLOCKED.
- FRAME_DATA  output  16  captured non-sync frame.
- FRAME_VALID  output  1  FRAME_DATA holds an unconsumed frame.
- FRAME_READY  input  1  consumer accepts the frame when FRAME_VALID & FRAME_READY.
- LOCKED  output  1  high in LOCKED state.
- FRAME_CNT  output  CNT_WIDTH  frames delivered; saturating.
- SYNC_CNT  output  CNT_WIDTH  sync words seen while LOCKED; saturating.
- OVF_CNT  output  8  frames dropped because the buffer was full; saturating.
- OVERFLOW  output  1  sticky; set on first drop.

Behaviour:
- Reset (CMD_RST_N low, asynchronous): state UNLOCKED, shift register 0, bit counter 0, and every output 0. Behaviour after CLEAR is identical, except that CLEAR is synchronous.
- Reset or CLEAR mid-frame discards the partial word and drops FRAME_VALID without a handshake.
- Sampling: when SER_EN=1, `sr <= {sr[14:0], SER_IN}`. When SER_EN=0, sr and the bit counter hold.
- Any SER_EN 1->0 transition while LOCKING or LOCKED returns to UNLOCKED and zeroes the bit counter. FRAME_VALID is unaffected.
- UNLOCKED:
  - After each sampled bit, compare the updated sr with SYNC_WORD (bit-level search).
  - On a match, the bit counter becomes 0 (word boundary), the lock counter becomes 1, and the next state is LOCKING, or LOCKED directly if LOCK_CNT=1.
- LOCKING:
  - The bit counter (4 bits) increments per sampled bit; a word completes when it wraps 15->0.
  - Completed word == SYNC_WORD: increment the lock counter. Reaching LOCK_CNT -> LOCKED.
  - Completed word != SYNC_WORD: back to UNLOCKED, lock counter 0.
  - No frames are emitted during LOCKING.
- LOCKED:
  - Completed word == SYNC_WORD: SYNC_CNT++ and the word is not emitted.
  - Any other completed word is a frame. It is emitted with no realignment; only SER_EN loss or CLEAR unlocks.
- Output buffer (1 entry):
  - A frame completing on the sampled bit at edge t gives FRAME_VALID=1 and FRAME_DATA=word after edge t. Latency is 1 cycle from the last bit.
  - A frame whose word completes while the buffer is occupied and FRAME_READY=0 at that edge is dropped: OVF_CNT++ (saturates at 255), OVERFLOW<=1, and FRAME_DATA keeps the old frame.
  - Handshake at the same edge as a new frame completing: the old frame is consumed and the new one is loaded, so FRAME_VALID stays 1 with no drop.
  - Handshake with no new frame: FRAME_VALID<=0.
  - FRAME_DATA is stable while FRAME_VALID=1 and FRAME_READY=0.
- FRAME_CNT increments when a frame is loaded into the buffer, not when it is dropped.
- All counters saturate at all-ones; they never wrap.
- CLEAR and a frame completion at the same edge: CLEAR wins and the frame is discarded.

Decomposition:
- Shared package cmd_pkg:
  - SYNC_WORD default constant.
  - State enum {UNLOCKED, LOCKING, LOCKED}, 2-bit encoding.
  - FRAME_W=16 constant.
  - Saturating-increment function.
- One natural sub-module, cmd_rx_align: shift register, bit counter and lock state machine. It outputs word/word_stb/is_sync.
- The top level holds the output buffer and the counters.

Test Plan:
- Lock at odd offset: 5 idle bits, then SYNC_WORD x4 (SER_EN=1) -> LOCKED=1 one cycle after the 64th sync bit, SYNC_CNT=0, FRAME_VALID=0.
- Frame delivery: locked, send 16'hA5C3 with FRAME_READY=1 -> FRAME_VALID pulses 1 cycle after the last bit, FRAME_DATA=A5C3, FRAME_CNT=1. A following SYNC_WORD gives SYNC_CNT=1 and no frame.
- Lock failure: SYNC x2, then 16'h1234 while LOCKING -> state UNLOCKED, LOCKED=0, no frame. Then SYNC x4 -> LOCKED.
- Backpressure: FRAME_READY=0, send 16'h0001, 16'h0002, 16'h0003 -> FRAME_DATA=0001, OVF_CNT=2, OVERFLOW=1, FRAME_CNT=1.
- Simultaneous: FRAME_READY rises on the same edge that frame 16'hBEEF completes with 16'hCAFE buffered -> CAFE consumed, BEEF loaded, OVF_CNT unchanged.
- Enable/reset: drop SER_EN mid-frame -> LOCKED=0 next cycle. Assert CMD_RST_N=0 asynchronously between edges -> all outputs 0 immediately. After release, SYNC x4 -> re-lock.
